fpga_cfg_loader: RTL and testbench
==================================

Name: fpga_cfg_loader

Overview:
- Drives the fabric configuration chain (prog_clk / ccff_head) from a byte stream supplied by an on-chip host port; it is the transmitting end of the chain that the fabric top shifts in.
- LOAD mode serialises exactly CHAIN_LEN bits into ccff_head, one bit per generated prog_clk rising edge.
- PROBE mode walks a single '1' through the chain and measures the chain length from ccff_tail.
- Sits between the tile's pad/host logic and the fabric top. prog_clk is a registered, divided strobe, not a separate clock domain for this block.

Parameters:
- CHAIN_LEN, 1024, number of configuration bits shifted per LOAD (>=1).
- DIV, 2, clk cycles per prog_clk half-period (>=1); bit period = 2*DIV clk cycles.
- PROBE_MAX, 4095, prog_clk rising edges before PROBE reports a timeout (must be < 2**CW).
- CW, 16, width of the bit/edge counters and probe_len.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; ignored while busy.
- mode  in  1  0 = LOAD, 1 = PROBE; sampled only when start is accepted.
- s_data  in  8  bitstream byte, sent LSB first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts s_data this cycle.
- prog_clk  out  1  configuration shift strobe to the fabric, registered.
- ccff_head  out  1  serial config data into the chain, registered.
- ccff_tail  in  1  chain serial output, sampled synchronously to clk.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  PROBE timeout; sticky until the next accepted start.
- probe_len  out  CW  measured chain length; held until the next PROBE.

Behaviour:
- Reset values (asynchronous, all outputs): s_ready=0, prog_clk=0, ccff_head=0, busy=0, done=0, error=0, probe_len=0. State goes to IDLE.
- Reset mid-operation aborts immediately. prog_clk drops to 0 without completing the edge. Chain contents are undefined afterwards, and the host must reload.
- States: IDLE, FETCH, SH_LO, SH_HI, PR_LO, PR_HI, DONE.
- IDLE:
  - On start: busy=1 next cycle, error cleared, bit counter cleared.
  - If mode=0, go to FETCH.
  - If mode=1, go to PR_LO with ccff_head=1 and edge counter=0.
- FETCH:
  - s_ready=1 combinationally when state==FETCH, otherwise 0.
  - A byte is accepted when s_valid and s_ready are both high. It goes into an 8-bit shift register, and the state moves to SH_LO.
  - prog_clk stays 0 for as long as the loader waits on s_valid.
- SH_LO:
  - On entry, ccff_head = shreg[0].
  - prog_clk=0 for DIV cycles, then go to SH_HI.
- SH_HI:
  - prog_clk=1 for DIV cycles. The 0->1 transition is the shift edge, and ccff_head has been stable for DIV cycles before it.
  - On exit: prog_clk returns to 0, shreg shifts right, and the bit counter increments.
  - If counter==CHAIN_LEN, go to DONE.
  - Else if 8 bits of the byte have been consumed, go to FETCH.
  - Else go to SH_LO.
- Final partial byte: only the low (CHAIN_LEN mod 8) bits are shifted. The remaining bits are discarded and no further byte is requested.
- PR_LO / PR_HI:
  - Same timing as SH_LO / SH_HI. The first bit is 1; ccff_head=0 after the first edge.
  - The edge counter increments on each rising edge.
  - ccff_tail is sampled in the last clk cycle of PR_HI.
  - If it reads 1: probe_len = edge count, go to DONE.
  - Else, if the edge count equals PROBE_MAX: error=1, probe_len=0, go to DONE.
- PROBE leaves the chain holding zeros except for the walked bit.
- DONE: lasts one cycle, with done=1, busy=0, prog_clk=0, ccff_head=0. Then go to IDLE.
- start asserted in any state other than IDLE is ignored, with no queueing.
- Simultaneous events:
  - start coincident with rst_n low: reset wins.
  - s_valid asserted outside FETCH: not consumed.
- Counters are CW bits wide and saturation never occurs because of the parameter constraints. Elaboration must fail if CHAIN_LEN or PROBE_MAX >= 2**CW.

Decomposition:
- Shared package fpga_cfg_pkg holds:
  - the state enum;
  - the MODE_LOAD and MODE_PROBE constants;
  - the default CW.
- One natural sub-module, fpga_cfg_strobe_gen. It is a DIV half-period counter that emits phase_lo_done and phase_hi_done, plus the registered prog_clk. It is shared by the LOAD and PROBE paths.

Test Plan:
- LOAD, CHAIN_LEN=20, DIV=1, bytes 0xA5, 0x3C, 0x0F offered back-to-back:
  - exactly 20 prog_clk rising edges;
  - ccff_head sampled at the edges is 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1;
  - exactly 3 handshakes;
  - one done pulse, with busy low on that cycle.
- Same LOAD with s_valid deasserted for 5 cycles before each byte:
  - prog_clk held low during each stall;
  - identical bit sequence;
  - the bit period remains 2 clk cycles.
- PROBE with DIV=2 against a 20-flop shift-chain model: probe_len=20, error=0, 20 rising edges, done pulse.
- PROBE with ccff_tail tied 0 and PROBE_MAX=63: 63 edges, then error=1, probe_len=0, done. error clears on the next start.
- rst_n pulsed low after the 7th edge of a LOAD: prog_clk, busy and s_ready drop to 0 asynchronously. A new start then completes a full 20-bit load correctly.
- start pulsed while busy mid-LOAD: ignored, with the bit count and done timing unchanged.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the fabric configuration loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpga_cfg_pkg;

    localparam int CW_DEF = 16;

    localparam logic MODE_LOAD  = 1'b0;
    localparam logic MODE_PROBE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SH_LO,
        SH_HI,
        PR_LO,
        PR_HI,
        DONE
    } state_t;

endpackage

// File: rtl/fpga_cfg_strobe_gen.sv
// Half-period timer and registered prog_clk strobe shared by the LOAD and PROBE paths.
// Latency: each phase lasts DIV clk cycles; prog_clk changes on the clk edge that ends a phase.
// Backpressure: none; the phase inputs come from the loader FSM, and a stalled FSM holds prog_clk low.
module fpga_cfg_strobe_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic phase_lo,
    input  logic phase_hi,
    output logic phase_lo_done,
    output logic phase_hi_done,
    output logic prog_clk
);

    localparam int            DW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          last;

    assign last          = (div_cnt == LAST);
    assign phase_lo_done = phase_lo && last;
    assign phase_hi_done = phase_hi && last;

    // Count clk cycles within the current half-period; restart at every phase boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if ((phase_lo || phase_hi) && !last) begin
            div_cnt <= div_cnt + DW'(1);
        end else begin
            div_cnt <= '0;
        end
    end

    // prog_clk rises as the low phase ends and falls as the high phase ends; it is low outside shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_clk <= 1'b0;
        end else if (phase_lo) begin
            prog_clk <= last;
        end else if (phase_hi) begin
            prog_clk <= !last;
        end else begin
            prog_clk <= 1'b0;
        end
    end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Serialises a host byte stream into the fabric config chain (LOAD), or measures the chain length by walking a '1' (PROBE).
// Latency: each bit takes 2*DIV clk cycles plus 1 FETCH cycle per byte; done pulses 1 cycle after the last falling edge.
// Backpressure: s_ready is high only in FETCH; prog_clk is held low while waiting for s_valid.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int DIV       = 2,
    parameter int PROBE_MAX = 4095,
    parameter int CW        = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          prog_clk,
    output logic          ccff_head,
    input  logic          ccff_tail,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [CW-1:0] probe_len
);

    if (CHAIN_LEN < 1 || CHAIN_LEN >= (2 ** CW)) begin : g_chain_len_check
        $error("fpga_cfg_loader: CHAIN_LEN must be in [1, 2**CW)");
    end
    if (PROBE_MAX < 1 || PROBE_MAX >= (2 ** CW)) begin : g_probe_max_check
        $error("fpga_cfg_loader: PROBE_MAX must be in [1, 2**CW)");
    end
    if (DIV < 1) begin : g_div_check
        $error("fpga_cfg_loader: DIV must be >= 1");
    end

    localparam logic [CW-1:0] CHAIN_LEN_C = CW'(CHAIN_LEN);
    localparam logic [CW-1:0] PROBE_MAX_C = CW'(PROBE_MAX);

    state_t        state;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          phase_lo;
    logic          phase_hi;
    logic          phase_lo_done;
    logic          phase_hi_done;

    assign s_ready  = (state == FETCH);
    assign phase_lo = (state == SH_LO) || (state == PR_LO);
    assign phase_hi = (state == SH_HI) || (state == PR_HI);
    assign cnt_inc  = cnt + CW'(1);

    fpga_cfg_strobe_gen #(
        .DIV (DIV)
    ) u_strobe (
        .clk           (clk),
        .rst_n         (rst_n),
        .phase_lo      (phase_lo),
        .phase_hi      (phase_hi),
        .phase_lo_done (phase_lo_done),
        .phase_hi_done (phase_hi_done),
        .prog_clk      (prog_clk)
    );

    // Control FSM: fetches bytes, presents one bit per strobe period, and walks/measures the probe bit.
    // cnt counts shifted bits in LOAD and rising edges in PROBE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_idx   <= '0;
            cnt       <= '0;
            ccff_head <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            probe_len <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        error   <= 1'b0;
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (mode == MODE_PROBE) begin
                            ccff_head <= 1'b1;
                            state     <= PR_LO;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (s_valid && s_ready) begin
                        shreg     <= s_data;
                        ccff_head <= s_data[0];
                        bit_idx   <= '0;
                        state     <= SH_LO;
                    end
                end
                SH_LO: begin
                    if (phase_lo_done) begin
                        state <= SH_HI;
                    end
                end
                SH_HI: begin
                    if (phase_hi_done) begin
                        shreg   <= {1'b0, shreg[7:1]};
                        cnt     <= cnt_inc;
                        bit_idx <= bit_idx + 3'd1;
                        // A full chain wins over the byte boundary, which drops unused bits of a partial byte.
                        if (cnt_inc == CHAIN_LEN_C) begin
                            ccff_head <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else if (bit_idx == 3'd7) begin
                            state <= FETCH;
                        end else begin
                            ccff_head <= shreg[1];
                            state     <= SH_LO;
                        end
                    end
                end
                PR_LO: begin
                    if (phase_lo_done) begin
                        cnt   <= cnt_inc;
                        state <= PR_HI;
                    end
                end
                PR_HI: begin
                    if (phase_hi_done) begin
                        // Head drops on the falling strobe so the walked '1' is shifted exactly once.
                        ccff_head <= 1'b0;
                        if (ccff_tail) begin
                            probe_len <= cnt;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else if (cnt == PROBE_MAX_C) begin
                            error     <= 1'b1;
                            probe_len <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= PR_LO;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
module tb_fpga_cfg_loader;
    import fpga_cfg_pkg::*;

    localparam int CL     = 20;
    localparam int DIV_A  = 1;
    localparam int PMAX_A = 63;
    localparam int DIV_B  = 2;
    localparam int NBYTES = (CL + 7) / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: LOAD tests and probe timeout (tail tied low)
    logic        start_a = 1'b0;
    logic        mode_a  = 1'b0;
    logic [7:0]  s_data  = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        prog_clk_a, head_a, busy_a, done_a, error_a;
    logic [15:0] plen_a;

    // Instance B: probe against a shift-chain model
    logic        start_b = 1'b0;
    logic        mode_b  = 1'b0;
    logic        s_ready_b;
    logic        prog_clk_b, head_b, busy_b, done_b, error_b, tail_b;
    logic [15:0] plen_b;
    logic [63:0] chain_b;
    logic [5:0]  tail_idx  = 6'd19;
    logic        chain_clr = 1'b0;

    fpga_cfg_loader #(.CHAIN_LEN(CL), .DIV(DIV_A), .PROBE_MAX(PMAX_A), .CW(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .prog_clk(prog_clk_a), .ccff_head(head_a), .ccff_tail(1'b0),
        .busy(busy_a), .done(done_a), .error(error_a), .probe_len(plen_a)
    );

    fpga_cfg_loader #(.CHAIN_LEN(CL), .DIV(DIV_B), .PROBE_MAX(4095), .CW(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b),
        .s_data(8'h00), .s_valid(1'b0), .s_ready(s_ready_b),
        .prog_clk(prog_clk_b), .ccff_head(head_b), .ccff_tail(tail_b),
        .busy(busy_b), .done(done_b), .error(error_b), .probe_len(plen_b)
    );

    // Variable-length configuration chain clocked by the generated strobe
    always @(posedge prog_clk_b or posedge chain_clr) begin
        if (chain_clr) chain_b <= '0;
        else           chain_b <= {chain_b[62:0], head_b};
    end
    assign tail_b = chain_b[tail_idx];

    // Monitors, sampled on the falling clk edge
    int   cyc = 0;
    int   edges_a = 0, ledge_a = 0, last_rise_a = 0, hs_a = 0, dones_a = 0, done_cyc_a = 0;
    int   done_bad_a = 0, stall_bad_a = 0, per_bad_a = 0;
    logic pc_q_a = 1'b0, busy_q_a = 1'b0;
    logic bit_q[$];
    int   edges_b = 0, ledge_b = 0, last_rise_b = 0, dones_b = 0, per_bad_b = 0;
    logic pc_q_b = 1'b0, busy_q_b = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (busy_a && !busy_q_a) ledge_a = 0;
        if (prog_clk_a && !pc_q_a) begin
            bit_q.push_back(head_a);
            if (ledge_a > 0 && (ledge_a % 8) != 0 && (cyc - last_rise_a) != 2 * DIV_A) per_bad_a++;
            last_rise_a = cyc;
            ledge_a++;
            edges_a++;
        end
        pc_q_a   = prog_clk_a;
        busy_q_a = busy_a;
        if (s_valid && s_ready) hs_a++;
        if (s_ready && prog_clk_a) stall_bad_a++;
        if (done_a) begin
            dones_a++;
            done_cyc_a = cyc;
            if (busy_a || prog_clk_a || head_a) done_bad_a++;
        end

        if (busy_b && !busy_q_b) ledge_b = 0;
        if (prog_clk_b && !pc_q_b) begin
            if (ledge_b > 0 && (cyc - last_rise_b) != 2 * DIV_B) per_bad_b++;
            last_rise_b = cyc;
            ledge_b++;
            edges_b++;
        end
        pc_q_b   = prog_clk_b;
        busy_q_b = busy_b;
        if (done_b) dones_b++;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One LOAD of CL bits; stall = idle cycles in FETCH before each byte, poke = start pulse mid-load
    task automatic do_load(input string tag, input logic [23:0] bytes, input int stall,
                           input bit poke, input logic [19:0] exp_bits);
        int e0, h0, d0, q0, sb0, pb0, db0, t0, wait_n;
        logic [19:0] got;
        e0 = edges_a; h0 = hs_a; d0 = dones_a; q0 = bit_q.size();
        sb0 = stall_bad_a; pb0 = per_bad_a; db0 = done_bad_a;
        start_a = 1'b1; mode_a = MODE_LOAD;
        @(posedge clk); #1;
        start_a = 1'b0;
        t0 = cyc + 1;
        chk({tag, "_error_cleared"}, error_a, 0);
        chk({tag, "_busy"}, busy_a, 1);
        for (int k = 0; k < NBYTES; k++) begin
            if (stall == 0) begin s_valid = 1'b1; s_data = bytes[8*k +: 8]; end
            wait_n = 0;
            while (!s_ready && wait_n < 400) begin @(posedge clk); #1; wait_n++; end
            if (!s_ready) begin
                chk({tag, "_ready_wait"}, s_ready, 1);
                s_valid = 1'b0;
                return;
            end
            if (stall > 0) begin
                repeat (stall) begin @(posedge clk); #1; end
                s_valid = 1'b1; s_data = bytes[8*k +: 8];
            end
            @(posedge clk); #1;
            s_valid = 1'b0;
            if (k == 0 && poke) begin
                start_a = 1'b1; mode_a = MODE_PROBE;
                @(posedge clk); #1;
                start_a = 1'b0; mode_a = MODE_LOAD;
            end
        end
        wait_n = 0;
        while (dones_a == d0 && wait_n < 400) begin @(negedge clk); #1; wait_n++; end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < CL; i++) got[i] = (q0 + i < bit_q.size()) ? bit_q[q0 + i] : 1'b0;
        chk({tag, "_edges"}, edges_a - e0, CL);
        chk({tag, "_bits"}, got, exp_bits);
        chk({tag, "_handshakes"}, hs_a - h0, NBYTES);
        chk({tag, "_done_pulses"}, dones_a - d0, 1);
        chk({tag, "_done_cycle_outs"}, done_bad_a - db0, 0);
        chk({tag, "_stall_prog_clk"}, stall_bad_a - sb0, 0);
        chk({tag, "_bit_period"}, per_bad_a - pb0, 0);
        chk({tag, "_latency"}, done_cyc_a - t0, NBYTES * (1 + stall) + CL * 2 * DIV_A);
        chk({tag, "_busy_after"}, busy_a, 0);
    endtask

    task automatic probe_b(input string tag, input int len);
        int e0, d0, p0, wait_n;
        tail_idx = 6'(len - 1);
        chain_clr = 1'b1; #1; chain_clr = 1'b0;
        e0 = edges_b; d0 = dones_b; p0 = per_bad_b;
        start_b = 1'b1; mode_b = MODE_PROBE;
        @(posedge clk); #1;
        start_b = 1'b0; mode_b = MODE_LOAD;
        wait_n = 0;
        while (dones_b == d0 && wait_n < 2000) begin @(negedge clk); #1; wait_n++; end
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_probe_len"}, plen_b, len);
        chk({tag, "_error"}, error_b, 0);
        chk({tag, "_edges"}, edges_b - e0, len);
        chk({tag, "_done_pulses"}, dones_b - d0, 1);
        chk({tag, "_period"}, per_bad_b - p0, 0);
    endtask

    typedef struct {
        logic [23:0] bytes;
        int          stall;
        bit          poke;
        logic [19:0] exp_bits;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   e0, d0, wait_n;
        logic pc_before;
        vecs[0] = '{24'h0F3CA5, 0, 1'b0, 20'hF3CA5};
        vecs[1] = '{24'h0F3CA5, 5, 1'b0, 20'hF3CA5};
        vecs[2] = '{24'hF000FF, 2, 1'b0, 20'h000FF};
        vecs[3] = '{24'hFF8100, 1, 1'b0, 20'hF8100};
        vecs[4] = '{24'h0F3CA5, 0, 1'b1, 20'hF3CA5};

        // Reset, with start held high during it
        chain_clr = 1'b1;
        start_a   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs_a", {s_ready, prog_clk_a, head_a, busy_a, done_a, error_a}, 0);
        chk("reset_plen_a", plen_a, 0);
        chk("reset_outs_b", {prog_clk_b, head_b, busy_b, done_b, error_b}, 0);
        start_a   = 1'b0;
        chain_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", {busy_a, s_ready}, 0);

        for (int v = 0; v < 5; v++) do_load($sformatf("vec%0d", v), vecs[v].bytes, vecs[v].stall,
                                            vecs[v].poke, vecs[v].exp_bits);

        // Probe timeout with tail stuck low
        e0 = edges_a; d0 = dones_a;
        start_a = 1'b1; mode_a = MODE_PROBE;
        @(posedge clk); #1;
        start_a = 1'b0; mode_a = MODE_LOAD;
        wait_n = 0;
        while (dones_a == d0 && wait_n < 1000) begin @(negedge clk); #1; wait_n++; end
        repeat (3) @(posedge clk);
        #1;
        chk("timeout_edges", edges_a - e0, PMAX_A);
        chk("timeout_error", error_a, 1);
        chk("timeout_plen", plen_a, 0);
        chk("timeout_done", dones_a - d0, 1);
        do_load("after_timeout", vecs[0].bytes, 0, 1'b0, vecs[0].exp_bits);

        // Asynchronous reset after the 7th edge of a load
        e0 = edges_a;
        start_a = 1'b1; mode_a = MODE_LOAD;
        @(posedge clk); #1;
        start_a = 1'b0;
        s_valid = 1'b1; s_data = 8'hA5;
        @(posedge clk); #1;
        s_valid = 1'b0;
        wait_n = 0;
        while (edges_a - e0 < 7 && wait_n < 100) begin @(negedge clk); #1; wait_n++; end
        pc_before = prog_clk_a;
        chk("midrst_prog_clk_high", pc_before, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_async_outs", {prog_clk_a, busy_a, s_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_load("after_midrst", 24'h0F3CA5, 0, 1'b0, 20'hF3CA5);

        // Probe against the chain model
        probe_b("probe20", 20);
        for (int r = 0; r < 4; r++) probe_b($sformatf("rprobe%0d", r), $urandom_range(1, 60));

        // Random loads checked against a bit-order model
        for (int r = 0; r < 6; r++) begin
            logic [23:0] rb;
            logic [19:0] eb;
            rb = 24'($urandom);
            for (int i = 0; i < CL; i++) eb[i] = 1'((rb >> (8 * (i / 8) + (i % 8))) & 24'd1);
            do_load($sformatf("rload%0d", r), rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), eb);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
